apu_share_arbiter: RTL

Round-robin arbiter that shares one pipelined, in-order APU (shared FPU/DSP-mult slot) among the cluster cores. It forwards one core request per cycle to the unit and tracks the issuing core in a tag FIFO. Each result is returned to the issuing core, registered. It sits in the cluster between the cores' APU ports and each shared execution unit, one instance per shared unit type.

---
 rtl/apu_share_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/apu_share_arbiter.sv
// Round-robin arbiter sharing one pipelined in-order APU among the cluster cores.
// Issuing-core tags ride a FIFO so in-order results can be routed back, registered.
module apu_share_arbiter #(
    parameter int unsigned NB_CORES = 4,
    parameter int unsigned NARGS    = 3,
    parameter int unsigned WOP      = 6,
    parameter int unsigned NDSFLAGS = 15,
    parameter int unsigned NUSFLAGS = 5,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NB_CORES-1:0]             core_req_i,
    output logic [NB_CORES-1:0]             core_gnt_o,
    input  logic [NB_CORES*NARGS*WIDTH-1:0] core_operands_i,
    input  logic [NB_CORES*WOP-1:0]         core_op_i,
    input  logic [NB_CORES*NDSFLAGS-1:0]    core_flags_i,
    output logic [NB_CORES-1:0]             core_rvalid_o,
    output logic [WIDTH-1:0]                core_result_o,
    output logic [NUSFLAGS-1:0]             core_rflags_o,
    output logic                            apu_req_o,
    input  logic                            apu_gnt_i,
    output logic [NARGS*WIDTH-1:0]          apu_operands_o,
    output logic [WOP-1:0]                  apu_op_o,
    output logic [NDSFLAGS-1:0]             apu_flags_o,
    input  logic                            apu_rvalid_i,
    input  logic [WIDTH-1:0]                apu_result_i,
    input  logic [NUSFLAGS-1:0]             apu_rflags_i,
    output logic                            err_o
);

    localparam int unsigned PtrW  = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = AddrW + 1;
    localparam int unsigned OpsW  = NARGS * WIDTH;

    logic [PtrW-1:0]       r_ptr;
    logic [PtrW-1:0]       r_tags [DEPTH];
    logic [AddrW-1:0]      r_wptr;
    logic [AddrW-1:0]      r_rptr;
    logic [CntW-1:0]       r_count;
    logic [NB_CORES-1:0]   r_rvalid;
    logic [WIDTH-1:0]      r_result;
    logic [NUSFLAGS-1:0]   r_rflags;
    logic                  r_err;

    logic [2*NB_CORES-1:0] w_rot;
    logic [PtrW-1:0]       w_off;
    logic [PtrW:0]         w_sum;
    logic [PtrW-1:0]       w_win;
    logic [PtrW-1:0]       w_ptr_nxt;
    logic [PtrW-1:0]       w_head;
    logic                  w_any;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_hs;
    logic                  w_pop;

    // Rotate requests so the pointer lands on bit 0; the lowest set bit is the winner offset.
    always_comb begin
        w_any = |core_req_i;
        w_rot = {core_req_i, core_req_i} >> r_ptr;
        w_off = '0;
        for (int k = NB_CORES - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = PtrW'(k);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (PtrW+1)'(NB_CORES)) begin
            w_win = PtrW'(w_sum - (PtrW+1)'(NB_CORES));
        end else begin
            w_win = w_sum[PtrW-1:0];
        end
        w_ptr_nxt = (w_win == PtrW'(NB_CORES - 1)) ? '0 : w_win + PtrW'(1);
    end

    assign w_full  = (r_count == CntW'(DEPTH));
    assign w_empty = (r_count == '0);
    // Full blocks issue even when a pop is pending, keeping gnt off the result path.
    assign apu_req_o = w_any & ~w_full;
    assign w_hs      = apu_req_o & apu_gnt_i;
    assign w_pop     = apu_rvalid_i & ~w_empty;
    assign w_head    = r_tags[r_rptr];

    always_comb begin
        apu_operands_o = '0;
        apu_op_o       = '0;
        apu_flags_o    = '0;
        core_gnt_o     = '0;
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            if (w_any && (w_win == PtrW'(i))) begin
                apu_operands_o = core_operands_i[i*OpsW +: OpsW];
                apu_op_o       = core_op_i[i*WOP +: WOP];
                apu_flags_o    = core_flags_i[i*NDSFLAGS +: NDSFLAGS];
            end
            core_gnt_o[i] = w_hs && (w_win == PtrW'(i));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_hs) begin
                r_ptr  <= w_ptr_nxt;
                r_wptr <= r_wptr + AddrW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AddrW'(1);
            if (w_hs && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hs) r_tags[r_wptr] <= w_win;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
            r_result <= '0;
            r_rflags <= '0;
            r_err    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NB_CORES; i++) begin
                r_rvalid[i] <= w_pop && (w_head == PtrW'(i));
            end
            if (w_pop) begin
                r_result <= apu_result_i;
                r_rflags <= apu_rflags_i;
            end
            if (apu_rvalid_i && w_empty) r_err <= 1'b1;
        end
    end

    assign core_rvalid_o = r_rvalid;
    assign core_result_o = r_result;
    assign core_rflags_o = r_rflags;
    assign err_o         = r_err;

endmodule
